agc_word_writer: RTL and testbench
==================================

// Module: agc_word_writer
// PURPOSE
//  Write-side counterpart of the ALU operand path: takes 15-bit 1's-complement ALU results,
//  generates odd parity, and writes 16-bit words {data[14:0], parity} to erasable memory.
//  A small FIFO decouples the ALU from the memory; the memory uses a req/ack handshake.
//  The word format matches what the ALU consumes: bits [15:1] are data, bit 0 is parity.
// PARAMETERS
//  ADDR_W         11  memory address width
//  DEPTH           4  FIFO entries, power of 2, >=2
//  NORM_NEG_ZERO   0  1: rewrite -0 (15'h7FFF) as +0 (15'h0000) before parity
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  in_valid   in   1       producer has a word
//  in_ready   out  1       FIFO not full; accept on edge when in_valid && in_ready
//  in_data    in   15      1's-complement result
//  in_addr    in   ADDR_W  destination address
//  mem_we     out  1       write request, held until mem_ack
//  mem_re     out  1       readback request (READBACK_CHECK_EN only, else 0)
//  mem_addr   out  ADDR_W  address of the current access
//  mem_wdata  out  16      {data, odd parity}
//  mem_rdata  in   16      readback data, sampled on ack in READ
//  mem_ack    in   1       memory completes the current access on this edge
//  busy       out  1       FIFO non-empty or FSM not IDLE
//  err_pulse  out  1       1-cycle readback mismatch flag (0 without macro)
//  err_count  out  8       saturating mismatch count (0 without macro)
// BEHAVIOUR
//  Reset (async, immediate): FIFO empty, FSM=IDLE, in_ready=1, mem_we=mem_re=0,
//   mem_addr=0, mem_wdata=0, busy=0, err_pulse=0, err_count=0. An in-flight access is abandoned.
//  Encode: d = (NORM_NEG_ZERO && in_data==15'h7FFF) ? 0 : in_data; p = ~^d;
//   word = {d, p}, so the 16-bit word always has an odd number of ones. Encode at push time.
//  FIFO: in_ready = (count != DEPTH), from registered state. No push while full, even if
//   a pop occurs on the same edge. A simultaneous push and pop when not full leaves count unchanged.
//  FSM IDLE: on an edge with FIFO non-empty, pop the head into mem_addr/mem_wdata and set mem_we=1 -> WRITE.
//   A word accepted on edge N gives mem_we=1 from edge N+1.
//  FSM WRITE: mem_we, mem_addr and mem_wdata are stable until the edge where mem_ack=1. On that edge:
//   without macro: if FIFO non-empty, pop the next word and stay in WRITE (back-to-back);
//   otherwise mem_we=0 -> IDLE.
//  mem_ack is ignored in IDLE. Ack and reset together: reset wins.
//  Words are written in strict acceptance order; no word is dropped or duplicated.
// CONFIGURATION
//  READBACK_CHECK_EN defined:
//   - On write ack: mem_we=0, mem_re=1 with the same mem_addr -> READ.
//   - In READ: on ack, compare mem_rdata with mem_wdata.
//   - On mismatch, or if mem_rdata has even parity: err_pulse=1 for one cycle and
//     err_count+1, saturating at 255.
//   - Then pop the next word (-> WRITE) or go to IDLE with mem_re=0.
//  Not defined: READ state absent; mem_re, err_pulse and err_count are tied to 0.
// TESTING
//  1. in_data=15'd4, in_addr=3, mem_ack the cycle after mem_we
//     -> mem_wdata=16'h0008, mem_addr=3, mem_we high exactly until the ack edge.
//  2. in_data=15'd3 -> 16'h0007. in_data=15'h7FFB (-4) -> 16'hFFF7.
//  3. in_data=15'h7FFF: NORM_NEG_ZERO=0 -> 16'hFFFE; NORM_NEG_ZERO=1 -> 16'h0001.
//  4. DEPTH=4, mem_ack=0, stream words 1..6
//     -> 5 accepted (1 in WRITE, 4 queued), in_ready=0 from then on;
//     then ack every cycle -> 5 writes in order with back-to-back mem_we, and busy drops after the last ack.
//  5. rst_n low while mem_we=1 and FIFO holds 2 words
//     -> mem_we=0 and busy=0 with no clock edge; after release, in_ready=1 and no write is issued.
//  6. READBACK_CHECK_EN: write 16'h0008, return mem_rdata=16'h0009
//     -> err_pulse for 1 cycle, err_count=1; correct readback -> no pulse.

Source files
------------

// File: rtl/agc_word_writer_if.sv
// Producer and erasable-memory bus for agc_word_writer.
// master = the writer itself, slave = producer plus memory side.
interface agc_word_writer_if #(
    parameter int ADDR_W = 11
);
    logic              in_valid;
    logic              in_ready;
    logic [14:0]       in_data;
    logic [ADDR_W-1:0] in_addr;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_ack;
    logic              busy;
    logic              err_pulse;
    logic [7:0]        err_count;

    modport master (
        input  in_valid, in_data, in_addr, mem_rdata, mem_ack,
        output in_ready, mem_we, mem_re, mem_addr, mem_wdata, busy, err_pulse, err_count
    );
    modport slave (
        output in_valid, in_data, in_addr, mem_rdata, mem_ack,
        input  in_ready, mem_we, mem_re, mem_addr, mem_wdata, busy, err_pulse, err_count
    );
endinterface

// File: rtl/agc_word_writer.sv
// Odd-parity encoder + FIFO + req/ack writer into erasable memory.
// Define READBACK_CHECK_EN to verify every write with a readback.
module agc_word_writer #(
    parameter int ADDR_W        = 11,
    parameter int DEPTH         = 4,
    parameter bit NORM_NEG_ZERO = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    agc_word_writer_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       word;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    entry_t            fifo_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    state_t            state;
    logic              push, pop, fifo_ne, slot_free;
    logic [14:0]       enc_d;
    entry_t            in_entry, head;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [15:0]       mem_wdata_q;

    assign enc_d    = (NORM_NEG_ZERO && bus.in_data == 15'h7FFF) ? 15'h0000 : bus.in_data;
    assign in_entry = '{addr: bus.in_addr, word: {enc_d, ~^enc_d}};
    assign head     = fifo_q[rd_ptr];

    assign fifo_ne      = (count != '0);
    assign bus.in_ready = (count != (PTR_W+1)'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;

    // The output register is free to take the next word once the access in flight completes.
`ifdef READBACK_CHECK_EN
    assign slot_free = (state == IDLE) || (state == READ && bus.mem_ack);
`else
    assign slot_free = (state == IDLE) || (state == WRITE && bus.mem_ack);
`endif
    assign pop = slot_free && fifo_ne;

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr] <= in_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

`ifdef READBACK_CHECK_EN
    logic       mem_re_q;
    logic       err_pulse_q;
    logic [7:0] err_count_q;
    logic       bad_read;

    assign bad_read = (bus.mem_rdata != mem_wdata_q) || !(^bus.mem_rdata);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef READBACK_CHECK_EN
            mem_re_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
`endif
        end else begin
`ifdef READBACK_CHECK_EN
            err_pulse_q <= 1'b0;
            if (state == READ && bus.mem_ack && bad_read) begin
                err_pulse_q <= 1'b1;
                if (err_count_q != 8'hFF) err_count_q <= err_count_q + 1'b1;
            end
`endif
            if (pop) begin
                state       <= WRITE;
                mem_we_q    <= 1'b1;
                mem_addr_q  <= head.addr;
                mem_wdata_q <= head.word;
`ifdef READBACK_CHECK_EN
                mem_re_q    <= 1'b0;
`endif
            end else begin
                case (state)
                    WRITE: if (bus.mem_ack) begin
                        mem_we_q <= 1'b0;
`ifdef READBACK_CHECK_EN
                        mem_re_q <= 1'b1;
                        state    <= READ;
`else
                        state    <= IDLE;
`endif
                    end
`ifdef READBACK_CHECK_EN
                    READ: if (bus.mem_ack) begin
                        mem_re_q <= 1'b0;
                        state    <= IDLE;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = fifo_ne || (state != IDLE);
`ifdef READBACK_CHECK_EN
    assign bus.mem_re    = mem_re_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_q;
`else
    assign bus.mem_re    = 1'b0;
    assign bus.err_pulse = 1'b0;
    assign bus.err_count = 8'h00;
`endif
endmodule

// File: tb/tb_agc_word_writer.sv
// Self-checking bench for agc_word_writer: directed scenarios plus a random stream
// scored against an in-order queue of expected {addr, word} writes.
module tb_agc_word_writer;
    localparam int ADDR_W = 11;
    localparam int DEPTH  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    agc_word_writer_if #(.ADDR_W(ADDR_W)) bus ();
    agc_word_writer_if #(.ADDR_W(ADDR_W)) bus_nz ();

    agc_word_writer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .NORM_NEG_ZERO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    agc_word_writer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .NORM_NEG_ZERO(1'b1)) dut_nz (
        .clk(clk), .rst_n(rst_n), .bus(bus_nz));

    // Second instance mirrors the first one's stimulus; only its encoded word is inspected.
    assign bus_nz.in_valid  = bus.in_valid;
    assign bus_nz.in_data   = bus.in_data;
    assign bus_nz.in_addr   = bus.in_addr;
    assign bus_nz.mem_ack   = bus.mem_ack;
    assign bus_nz.mem_rdata = bus.mem_rdata;

    function automatic logic [15:0] model_word(input logic [14:0] d, input bit norm);
        logic [14:0] v;
        v = (norm && d == 15'h7FFF) ? 15'd0 : d;
        return {v, ($countones(v) % 2 == 0) ? 1'b1 : 1'b0};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [14:0] d, input logic [ADDR_W-1:0] a,
                            output logic [15:0] w, output logic [15:0] w_nz,
                            output logic [ADDR_W-1:0] ao);
        int k;
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_addr = a;
        tick;
        bus.in_valid = 1'b0;
        k = 0;
        while (!bus.mem_we && k < 20) begin tick; k++; end
        n_checks++;
        if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL write_start_timeout: mem_we=%b required 1", bus.mem_we); end
        w = bus.mem_wdata; w_nz = bus_nz.mem_wdata; ao = bus.mem_addr;
        bus.mem_ack = 1'b1; tick; bus.mem_ack = 1'b0;
`ifdef READBACK_CHECK_EN
        k = 0;
        while (!bus.mem_re && k < 20) begin tick; k++; end
        bus.mem_rdata = bus.mem_wdata; bus.mem_ack = 1'b1; tick; bus.mem_ack = 1'b0;
`endif
    endtask

    task automatic test_reset;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_addr = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        #3;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
        n_checks++; if (bus.mem_re !== 1'b0) begin n_fail++; $display("FAIL reset_mem_re: got %b want 0", bus.mem_re); end
        n_checks++; if (bus.mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
        n_checks++; if (bus.mem_wdata !== 16'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err_pulse: got %b want 0", bus.err_pulse); end
        n_checks++; if (bus.err_count !== 8'h0) begin n_fail++; $display("FAIL reset_err_count: got %h want 0", bus.err_count); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single;
        bus.in_valid = 1'b1; bus.in_data = 15'd4; bus.in_addr = 11'd3;
        tick;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL single_we_early: got %b want 0", bus.mem_we); end
        tick;
        n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b want 1", bus.mem_we); end
        n_checks++; if (bus.mem_addr !== 11'd3) begin n_fail++; $display("FAIL single_addr: got %h want 3", bus.mem_addr); end
        n_checks++; if (bus.mem_wdata !== 16'h0008) begin n_fail++; $display("FAIL single_wdata: got %h want 0008", bus.mem_wdata); end
        bus.mem_ack = 1'b1; tick; bus.mem_ack = 1'b0;
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL single_we_after_ack: got %b want 0", bus.mem_we); end
`ifdef READBACK_CHECK_EN
        n_checks++; if (bus.mem_re !== 1'b1) begin n_fail++; $display("FAIL single_re: got %b want 1", bus.mem_re); end
        bus.mem_rdata = 16'h0008; bus.mem_ack = 1'b1; tick; bus.mem_ack = 1'b0;
        n_checks++; if (bus.err_pulse !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", bus.err_pulse); end
`endif
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_encode;
        logic [15:0] w, w_nz;
        logic [ADDR_W-1:0] ao;
        do_write(15'd3, 11'd10, w, w_nz, ao);
        n_checks++; if (w !== 16'h0007) begin n_fail++; $display("FAIL enc_3: got %h want 0007", w); end
        n_checks++; if (ao !== 11'd10) begin n_fail++; $display("FAIL enc_3_addr: got %h want 00a", ao); end
        do_write(15'h7FFB, 11'd11, w, w_nz, ao);
        n_checks++; if (w !== 16'hFFF7) begin n_fail++; $display("FAIL enc_m4: got %h want fff7", w); end
        n_checks++; if (w_nz !== 16'hFFF7) begin n_fail++; $display("FAIL enc_m4_nz: got %h want fff7", w_nz); end
        do_write(15'h7FFF, 11'd12, w, w_nz, ao);
        n_checks++; if (w !== 16'hFFFE) begin n_fail++; $display("FAIL enc_negzero: got %h want fffe", w); end
        n_checks++; if (w_nz !== 16'h0001) begin n_fail++; $display("FAIL enc_negzero_norm: got %h want 0001", w_nz); end
    endtask

    task automatic test_fifo_full;
        int k, acc, nw, cyc;
        bit take;
        logic [ADDR_W-1:0] wa [5];
        logic [15:0]       wd [5];
        bus.mem_ack = 1'b0;
        k = 1; acc = 0;
        for (int c = 0; c < 12; c++) begin
            bus.in_valid = 1'b1; bus.in_data = 15'(k); bus.in_addr = ADDR_W'(16 + k);
            take = bus.in_ready;
            tick;
            if (take) begin acc++; k++; end
        end
        bus.in_valid = 1'b0;
        n_checks++; if (acc != 5) begin n_fail++; $display("FAIL full_accepted: got %0d want 5", acc); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
        n_checks++; if (bus.mem_addr !== 11'd17) begin n_fail++; $display("FAIL full_head_addr: got %h want 011", bus.mem_addr); end
        bus.mem_ack = 1'b1;
        nw = 0; cyc = 0;
        while (nw < 5 && cyc < 40) begin
            bus.mem_rdata = bus.mem_wdata;
            if (bus.mem_we) begin wa[nw] = bus.mem_addr; wd[nw] = bus.mem_wdata; nw++; end
            tick; cyc++;
        end
`ifdef READBACK_CHECK_EN
        bus.mem_rdata = bus.mem_wdata; tick;
`endif
        bus.mem_ack = 1'b0;
        n_checks++; if (nw != 5) begin n_fail++; $display("FAIL full_writes: got %0d want 5", nw); end
        for (int i = 0; i < nw; i++) begin
            n_checks++;
            if (wa[i] !== ADDR_W'(17 + i) || wd[i] !== model_word(15'(i + 1), 1'b0)) begin
                n_fail++; $display("FAIL full_order[%0d]: got %h/%h want %h/%h", i, wa[i], wd[i], ADDR_W'(17 + i), model_word(15'(i + 1), 1'b0));
            end
        end
`ifndef READBACK_CHECK_EN
        n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL full_back_to_back: got %0d cycles want 5", cyc); end
`endif
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_end: got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_midflight;
        bit we_seen;
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 15'(100 + i); bus.in_addr = ADDR_W'(40 + i);
            tick;
        end
        bus.in_valid = 1'b0;
        n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL mid_we_before: got %b want 1", bus.mem_we); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL mid_we_reset: got %b want 0", bus.mem_we); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_reset: got %b want 0", bus.busy); end
        #2 rst_n = 1'b1;
        we_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin tick; if (bus.mem_we) we_seen = 1'b1; end
        n_checks++; if (we_seen !== 1'b0) begin n_fail++; $display("FAIL mid_no_write: got we_seen=%b want 0", we_seen); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_readback;
`ifdef READBACK_CHECK_EN
        logic [15:0] rd [2];
        rd[0] = 16'h0009; rd[1] = 16'h0008;
        for (int r = 0; r < 2; r++) begin
            bus.in_valid = 1'b1; bus.in_data = 15'd4; bus.in_addr = 11'd3;
            tick; bus.in_valid = 1'b0;
            for (int k = 0; k < 20 && !bus.mem_we; k++) tick;
            bus.mem_ack = 1'b1; tick; bus.mem_ack = 1'b0;
            n_checks++; if (bus.mem_re !== 1'b1 || bus.mem_addr !== 11'd3) begin n_fail++; $display("FAIL rb_read_req: got re=%b addr=%h want 1/003", bus.mem_re, bus.mem_addr); end
            bus.mem_rdata = rd[r]; bus.mem_ack = 1'b1; tick; bus.mem_ack = 1'b0;
            n_checks++; if (bus.err_pulse !== (r == 0)) begin n_fail++; $display("FAIL rb_pulse[%0d]: got %b want %b", r, bus.err_pulse, r == 0); end
            n_checks++; if (bus.err_count !== 8'd1) begin n_fail++; $display("FAIL rb_count[%0d]: got %0d want 1", r, bus.err_count); end
            tick;
            n_checks++; if (bus.err_pulse !== 1'b0) begin n_fail++; $display("FAIL rb_pulse_clear[%0d]: got %b want 0", r, bus.err_pulse); end
        end
`endif
    endtask

    task automatic test_random;
        logic [ADDR_W+15:0] exp_q [$];
        logic [ADDR_W-1:0]  p_addr;
        logic [15:0]        p_word;
        bit acc, wr, hold;
        int n_w;
        n_w = 0;
        for (int c = 0; c < 500; c++) begin
            bus.in_valid  = (c < 350) && ($urandom_range(0, 2) != 0);
            bus.in_data   = 15'($urandom);
            bus.in_addr   = ADDR_W'($urandom);
            bus.mem_ack   = (bus.mem_we || bus.mem_re) && ($urandom_range(0, 1) == 1);
            bus.mem_rdata = bus.mem_wdata;
            acc  = bus.in_valid && bus.in_ready;
            wr   = bus.mem_we && bus.mem_ack;
            hold = bus.mem_we && !bus.mem_ack;
            p_addr = bus.mem_addr; p_word = bus.mem_wdata;
            if (acc) exp_q.push_back({bus.in_addr, model_word(bus.in_data, 1'b0)});
            if (wr) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_extra_write: got %h/%h want none", bus.mem_addr, bus.mem_wdata);
                end else begin
                    if ({bus.mem_addr, bus.mem_wdata} !== exp_q[0]) begin
                        n_fail++; $display("FAIL rand_write[%0d]: got %h/%h want %h", n_w, bus.mem_addr, bus.mem_wdata, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                n_w++;
            end
            tick;
            if (hold) begin
                n_checks++;
                if (bus.mem_we !== 1'b1 || bus.mem_addr !== p_addr || bus.mem_wdata !== p_word) begin
                    n_fail++; $display("FAIL rand_hold: got %b/%h/%h want 1/%h/%h", bus.mem_we, bus.mem_addr, bus.mem_wdata, p_addr, p_word);
                end
            end
            n_checks++; if (bus.err_pulse !== 1'b0) begin n_fail++; $display("FAIL rand_err_pulse: got %b want 0", bus.err_pulse); end
        end
        bus.in_valid = 1'b0; bus.mem_ack = 1'b0;
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain: got %0d pending want 0", exp_q.size()); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rand_busy: got %b want 0", bus.busy); end
        n_checks++; if (n_w < 50) begin n_fail++; $display("FAIL rand_volume: got %0d writes want >=50", n_w); end
        n_checks++; if (bus.err_count !== 8'h0) begin n_fail++; $display("FAIL rand_err_count: got %h want 0", bus.err_count); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_encode;
        test_fifo_full;
        test_reset_midflight;
        test_readback;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
